// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cacheline to 64-bit burst memory adaptor
// Optional idle-beat watchdog enabled by defining CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor #(
  parameter int LINE_W         = 256,
  parameter int BURST_W        = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  output logic               err_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] wr_line;
  logic              busy;
  logic              timeout;
  logic [31:0]       aligned_addr;
  logic              unused_addr_bits;

  assign busy             = (state == RD_BURST) || (state == WR_BURST);
  assign aligned_addr     = {address_i[31:OFF_W], {OFF_W{1'b0}}};
  assign unused_addr_bits = &{1'b0, address_i[OFF_W-1:0]};

  // Write beats come straight from the latched line so a beat is valid the cycle cnt moves.
  assign burst_o = (state == WR_BURST) ? wr_line[BURST_W*cnt +: BURST_W] : '0;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  assign timeout = busy && !resp_i && (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd    <= '0;
      err_o <= 1'b0;
    end else begin
      err_o <= timeout;
      if (busy && !resp_i && !timeout) wd <= wd + 1'b1;
      else                             wd <= '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      line_o    <= '0;
      wr_line   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          if (write_i) begin
            wr_line   <= line_i;
            address_o <= aligned_addr;
            write_o   <= 1'b1;
            state     <= WR_BURST;
          end else if (read_i) begin
            address_o <= aligned_addr;
            read_o    <= 1'b1;
            state     <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            line_o[BURST_W*cnt +: BURST_W] <= burst_i;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              cnt    <= '0;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end
          end else if (timeout) begin
            cnt    <= '0;
            read_o <= 1'b0;
            resp_o <= 1'b1;
            state  <= DONE;
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              cnt     <= '0;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end
          end else if (timeout) begin
            cnt     <= '0;
            write_o <= 1'b0;
            resp_o  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor
`timescale 1ns/1ps
module tb_cacheline_adaptor;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic         resp_o;
  logic         err_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cacheline_adaptor #(.LINE_W(256), .BURST_W(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .resp_o(resp_o), .err_o(err_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: which request is in flight, how many beats moved, the line words.
  int          m_kind;   // 0 none, 1 read, 2 write
  int          m_beats;
  int          m_silent;
  bit          m_done;
  bit          m_err;
  logic [31:0] m_addr;
  logic [63:0] m_line [4];
  logic [63:0] m_wline [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind = 0; m_beats = 0; m_silent = 0; m_done = 0; m_err = 0; m_addr = '0;
      for (int i = 0; i < 4; i++) begin m_line[i] = '0; m_wline[i] = '0; end
    end else if (m_done) begin
      m_done = 0; m_err = 0;
    end else if (m_kind == 0) begin
      if (write_i) begin
        m_kind = 2; m_addr = address_i & 32'hFFFF_FFE0;
        for (int i = 0; i < 4; i++) m_wline[i] = line_i[64*i +: 64];
      end else if (read_i) begin
        m_kind = 1; m_addr = address_i & 32'hFFFF_FFE0;
      end
    end else if (resp_i) begin
      m_silent = 0;
      if (m_kind == 1) m_line[m_beats] = burst_i;
      m_beats++;
      if (m_beats == 4) begin m_beats = 0; m_kind = 0; m_done = 1; end
    end else begin
      m_silent++;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      if (m_silent == TO) begin
        m_silent = 0; m_beats = 0; m_kind = 0; m_done = 1; m_err = 1;
      end
`endif
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("cyc_read_o", read_o, m_kind == 1);
      chk("cyc_write_o", write_o, m_kind == 2);
      chk("cyc_resp_o", resp_o, m_done);
      chk("cyc_err_o", err_o, m_err);
      chk("cyc_line_o", line_o, {m_line[3], m_line[2], m_line[1], m_line[0]});
      chk("cyc_burst_o", burst_o, (m_kind == 2) ? m_wline[m_beats] : 64'h0);
      if (m_kind != 0) chk("cyc_address_o", address_o, m_addr);
    end
  end

  task automatic cyc(input logic r, input logic w, input logic rs, input logic [63:0] b);
    read_i = r; write_i = w; resp_i = rs; burst_i = b;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1);
  end

  logic [63:0] wexp [6];
  bit          wpat [6];
  int          n;

  initial begin
    wexp = '{64'hD0, 64'hD1, 64'hD1, 64'hD2, 64'hD3, 64'hD3};
    wpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_line_o", line_o, 256'h0);
    chk("rst_burst_o", burst_o, 64'h0);
    chk("rst_address_o", address_o, 32'h0);
    chk("rst_ctrl", {read_o, write_o, resp_o, err_o}, 4'b0000);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Read 0x1234, four back-to-back beats
    address_i = 32'h0000_1234;
    cyc(1, 0, 0, 0);
    chk("rd_read_o", read_o, 1'b1);
    chk("rd_address_o", address_o, 32'h0000_1220);
    cyc(1, 0, 1, 64'hA0); cyc(1, 0, 1, 64'hA1); cyc(1, 0, 1, 64'hA2); cyc(1, 0, 1, 64'hA3);
    chk("rd_resp_o", resp_o, 1'b1);
    chk("rd_line_o", line_o, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    cyc(0, 0, 0, 0);
    chk("rd_resp_pulse", resp_o, 1'b0);
    cyc(0, 0, 0, 0);

    // Write 0x80000040 with gaps in resp_i
    address_i = 32'h8000_0040;
    line_i = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    cyc(0, 1, 0, 0);
    chk("wr_write_o", write_o, 1'b1);
    chk("wr_address_o", address_o, 32'h8000_0040);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wr_burst_o_%0d", i), burst_o, wexp[i]);
      chk($sformatf("wr_no_resp_%0d", i), resp_o, 1'b0);
      cyc(0, 1, wpat[i], 0);
    end
    chk("wr_resp_o", resp_o, 1'b1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Both requests asserted: write wins
    address_i = 32'h0000_0100;
    line_i = {64'h44, 64'h33, 64'h22, 64'h11};
    cyc(1, 1, 0, 0);
    chk("both_write_o", write_o, 1'b1);
    chk("both_read_o", read_o, 1'b0);
    chk("both_burst0", burst_o, 64'h11);
    repeat (4) cyc(1, 1, 1, 0);
    chk("both_resp_o", resp_o, 1'b1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Reset asserted after two read beats
    address_i = 32'h0000_2000;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 64'hB0); cyc(1, 0, 1, 64'hB1);
    read_i = 1'b0; resp_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_read_o", read_o, 1'b0);
    chk("arst_line_o", line_o, 256'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk("arst_idle", {read_o, write_o, resp_o}, 3'b000);
    address_i = 32'h0000_3000;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 64'hC0);
    chk("arst_beat0", line_o, {192'h0, 64'hC0});
    cyc(1, 0, 1, 64'hC1); cyc(1, 0, 1, 64'hC2); cyc(1, 0, 1, 64'hC3);
    chk("arst_line_done", line_o, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Back-to-back reads, request held through resp_o
    address_i = 32'h0000_0040;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 64'hE0); cyc(1, 0, 1, 64'hE1); cyc(1, 0, 1, 64'hE2); cyc(1, 0, 1, 64'hE3);
    chk("b2b_resp1", resp_o, 1'b1);
    address_i = 32'h0000_007F;
    cyc(1, 0, 0, 0);
    chk("b2b_gap", {read_o, resp_o}, 2'b00);
    cyc(1, 0, 0, 0);
    chk("b2b_read_o", read_o, 1'b1);
    chk("b2b_address_o", address_o, 32'h0000_0060);
    cyc(1, 0, 1, 64'hF0);
    chk("b2b_beat0", line_o, {64'hE3, 64'hE2, 64'hE1, 64'hF0});
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 64'hF1);
    chk("b2b_beat1", line_o, {64'hE3, 64'hE2, 64'hF1, 64'hF0});
    cyc(1, 0, 1, 64'hF2); cyc(1, 0, 1, 64'hF3);
    chk("b2b_resp2", resp_o, 1'b1);
    chk("b2b_line", line_o, {64'hF3, 64'hF2, 64'hF1, 64'hF0});
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    // One beat then silence: watchdog ends the burst with err_o
    address_i = 32'h0000_0500;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 64'h99);
    n = 0;
    while (n < 20 && !resp_o) begin
      cyc(1, 0, 0, 0);
      n++;
    end
    chk("to_silent_cycles", n, 8);
    chk("to_err_o", {resp_o, err_o}, 2'b11);
    chk("to_partial", line_o[63:0], 64'h99);
    cyc(0, 0, 0, 0);
    chk("to_idle", {read_o, resp_o, err_o}, 3'b000);
    cyc(0, 0, 0, 0);
`else
    n = 0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
